// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry, word widths, arbiter state encoding
// and the RGB colour constants used by the render path.
package fb_pkg;

   localparam int FB_W        = 64;
   localparam int FB_H        = 48;
   localparam int ADDR_W      = 15;
   localparam int DATA_W      = 24;
   localparam int RD_LATENCY  = 2;
   localparam int WR_MAX_WAIT = 16;
   localparam int STAT_W      = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD   = 2'd1,
      ARB_WR   = 2'd2
   } arb_state_t;

   // Colour words are packed {R,G,B}, 8 bits per channel.
   localparam logic [DATA_W-1:0] RGB_BLACK  = 24'h000000;
   localparam logic [DATA_W-1:0] RGB_WHITE  = 24'hFFFFFF;
   localparam logic [DATA_W-1:0] RGB_RED    = 24'hFF0000;
   localparam logic [DATA_W-1:0] RGB_GREEN  = 24'h00FF00;
   localparam logic [DATA_W-1:0] RGB_BLUE   = 24'h0000FF;
   localparam logic [DATA_W-1:0] RGB_ORANGE = 24'hFF4000;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                 input logic              inc);
      return (inc && (v != {STAT_W{1'b1}})) ? v + 1'b1 : v;
   endfunction

endpackage

// File: rtl/fb_rd_valid_pipe.sv
// Read-valid delay line: a DEPTH-stage shift register with synchronous clear,
// so in-flight read tokens vanish when the arbiter is reset.
module fb_rd_valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic in_valid,
   output logic out_valid
);

   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = in_valid;
   end

   always_ff @(posedge clk) begin
      if (clr) pipe_q <= '0;
      else     pipe_q <= pipe_d;
   end

   assign out_valid = pipe_q[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads win by default, a starvation
// guard forces a write slot. Optional per-frame grant statistics: FB_ARB_STATS_EN.
module fb_port_arbiter #(
   parameter int ADDR_W      = fb_pkg::ADDR_W,
   parameter int DATA_W      = fb_pkg::DATA_W,
   parameter int RD_LATENCY  = fb_pkg::RD_LATENCY,
   parameter int WR_MAX_WAIT = fb_pkg::WR_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   input  logic              frame_done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy
`ifdef FB_ARB_STATS_EN
   ,
   output logic [15:0]       stat_wr_cnt,
   output logic [15:0]       stat_force_cnt
`endif
);

   import fb_pkg::*;

   localparam int                WAIT_W   = $clog2(WR_MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WR_MAX_WAIT);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_wren_q, mem_wren_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              force_slot;

   assign force_slot = (wait_cnt_q == WAIT_MAX);

   // Grants are suppressed during reset so a request held across reset is dropped.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first; a
      // path that leaves one unassigned would infer a latch.
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
      if (!rst) begin
         if (force_slot && wr_req) wr_gnt = 1'b1;
         else if (rd_req)          rd_gnt = 1'b1;
         else                      wr_gnt = wr_req;
      end
   end

   always_comb begin
      state_d       = ARB_IDLE;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      mem_wren_d    = 1'b0;
      if (rd_gnt) begin
         state_d       = ARB_RD;
         mem_address_d = rd_addr;
      end else if (wr_gnt) begin
         state_d       = ARB_WR;
         mem_address_d = wr_addr;
         mem_data_d    = wr_data;
         mem_wren_d    = 1'b1;
      end

      if (wr_req && !wr_gnt) wait_cnt_d = force_slot ? wait_cnt_q : wait_cnt_q + 1'b1;
      else                   wait_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q       <= ARB_IDLE;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_wren_q    <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         mem_wren_q    <= mem_wren_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   fb_rd_valid_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_rd_valid_pipe (
      .clk       (clk),
      .clr       (rst),
      .in_valid  (rd_gnt),
      .out_valid (rd_valid)
   );

   assign rd_data     = mem_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_wren    = mem_wren_q;
   assign busy        = (state_q != ARB_IDLE);

`ifdef FB_ARB_STATS_EN
   logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [STAT_W-1:0] force_cnt_q, force_cnt_d;
   logic [STAT_W-1:0] stat_wr_cnt_q, stat_wr_cnt_d;
   logic [STAT_W-1:0] stat_force_cnt_q, stat_force_cnt_d;
   logic              forced_gnt;

   assign forced_gnt = wr_gnt && force_slot;

   // A grant in the frame_done cycle opens the new frame's count.
   always_comb begin
      stat_wr_cnt_d    = stat_wr_cnt_q;
      stat_force_cnt_d = stat_force_cnt_q;
      wr_cnt_d         = sat_inc(wr_cnt_q, wr_gnt);
      force_cnt_d      = sat_inc(force_cnt_q, forced_gnt);
      if (frame_done) begin
         stat_wr_cnt_d    = wr_cnt_q;
         stat_force_cnt_d = force_cnt_q;
         wr_cnt_d         = STAT_W'(wr_gnt);
         force_cnt_d      = STAT_W'(forced_gnt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q         <= '0;
         force_cnt_q      <= '0;
         stat_wr_cnt_q    <= '0;
         stat_force_cnt_q <= '0;
      end else begin
         wr_cnt_q         <= wr_cnt_d;
         force_cnt_q      <= force_cnt_d;
         stat_wr_cnt_q    <= stat_wr_cnt_d;
         stat_force_cnt_q <= stat_force_cnt_d;
      end
   end

   assign stat_wr_cnt    = stat_wr_cnt_q;
   assign stat_force_cnt = stat_force_cnt_q;
`else
   logic unused_frame_done;
   assign unused_frame_done = frame_done;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fb_port_arbiter;

   localparam int AW   = 15;
   localparam int DW   = 24;
   localparam int LAT  = 2;
   localparam int MAXW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_gnt;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_gnt;
   logic          frame_done = 1'b0;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic [DW-1:0] mem_q;
   logic          busy;
`ifdef FB_ARB_STATS_EN
   logic [15:0]   stat_wr_cnt;
   logic [15:0]   stat_force_cnt;
`endif

   always #5 clk = ~clk;

   fb_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .RD_LATENCY  (LAT),
      .WR_MAX_WAIT (MAXW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_gnt      (rd_gnt),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_gnt      (wr_gnt),
      .frame_done  (frame_done),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q),
      .busy        (busy)
`ifdef FB_ARB_STATS_EN
      ,
      .stat_wr_cnt    (stat_wr_cnt),
      .stat_force_cnt (stat_force_cnt)
`endif
   );

   // Single-port synchronous RAM with one cycle of read latency.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: who wins this cycle, what the RAM port shows
   // next, and when each read's data must appear.
   typedef struct {
      int            t;
      logic [DW-1:0] d;
   } rd_exp_t;

   bit            m_ok = 1'b0;
   int            m_wait = 0;
   int            m_cyc = 0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   bit            m_wren, m_busy;
   logic [DW-1:0] m_mem [int];
   rd_exp_t       rq [$];

   always @(negedge clk) begin
      bit            eg_r, eg_w, ev;
      logic [DW-1:0] rv;
      m_cyc++;
      eg_r = 1'b0;
      eg_w = 1'b0;
      if (!rst) begin
         if (m_wait == MAXW && wr_req) eg_w = 1'b1;
         else if (rd_req)              eg_r = 1'b1;
         else                          eg_w = wr_req;
      end
      check("model rd_gnt", 32'(rd_gnt), 32'(eg_r));
      check("model wr_gnt", 32'(wr_gnt), 32'(eg_w));
      if (m_ok) begin
         ev = (rq.size() > 0) && (rq[0].t == m_cyc);
         check("model mem_wren", 32'(mem_wren), 32'(m_wren));
         check("model mem_address", 32'(mem_address), 32'(m_addr));
         check("model mem_data", 32'(mem_data), 32'(m_data));
         check("model busy", 32'(busy), 32'(m_busy));
         check("model rd_valid", 32'(rd_valid), 32'(ev));
         if (ev) begin
            check("model rd_data", 32'(rd_data), 32'(rq[0].d));
            void'(rq.pop_front());
         end
      end
      if (rst) begin
         m_ok   = 1'b1;
         m_wait = 0;
         m_addr = '0;
         m_data = '0;
         m_wren = 1'b0;
         m_busy = 1'b0;
         rq.delete();
      end else begin
         m_wren = 1'b0;
         m_busy = eg_r || eg_w;
         if (eg_r) begin
            m_addr = rd_addr;
            rv = m_mem.exists(int'(rd_addr)) ? m_mem[int'(rd_addr)] : '0;
            rq.push_back('{t: m_cyc + LAT, d: rv});
         end
         if (eg_w) begin
            m_addr = wr_addr;
            m_data = wr_data;
            m_wren = 1'b1;
            m_mem[int'(wr_addr)] = wr_data;
         end
         if (wr_req && !eg_w) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
         else                 m_wait = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with both requesters active: nothing granted, nothing issued.
      rd_req  = 1'b1; rd_addr = 15'h0010;
      wr_req  = 1'b1; wr_addr = 15'h0020; wr_data = 24'hABCDEF;
      repeat (2) tick();
      check("reset rd_gnt", 32'(rd_gnt), 32'd0);
      check("reset wr_gnt", 32'(wr_gnt), 32'd0);
      check("reset mem_wren", 32'(mem_wren), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset mem_address", 32'(mem_address), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      tick();
      check("post reset mem_wren", 32'(mem_wren), 32'd0);

      // Single write.
      wr_req = 1'b1; wr_addr = 15'h028C; wr_data = 24'hFF4000;
      #1 check("single wr_gnt", 32'(wr_gnt), 32'd1);
      tick();
      wr_req = 1'b0;
      check("single mem_wren", 32'(mem_wren), 32'd1);
      check("single mem_address", 32'(mem_address), 32'h028C);
      check("single mem_data", 32'(mem_data), 32'hFF4000);
      tick();
      check("single mem_wren drop", 32'(mem_wren), 32'd0);

      // Read back.
      rd_req = 1'b1; rd_addr = 15'h028C;
      #1 check("readback rd_gnt", 32'(rd_gnt), 32'd1);
      tick();
      rd_req = 1'b0;
      check("readback rd_valid early", 32'(rd_valid), 32'd0);
      tick();
      check("readback rd_valid", 32'(rd_valid), 32'd1);
      check("readback rd_data", 32'(rd_data), 32'hFF4000);
      tick();
      check("readback rd_valid single", 32'(rd_valid), 32'd0);

      // Read granted the cycle right after a write to the same address.
      wr_req = 1'b1; wr_addr = 15'h0100; wr_data = 24'h123456;
      tick();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 15'h0100;
      #1 check("raw rd_gnt", 32'(rd_gnt), 32'd1);
      tick();
      rd_req = 1'b0;
      tick();
      check("raw rd_valid", 32'(rd_valid), 32'd1);
      check("raw rd_data", 32'(rd_data), 32'h123456);
      tick();

      // Starvation guard: RRRRW repeating while both requesters hold.
      rd_req = 1'b1; rd_addr = 15'h028C;
      wr_req = 1'b1; wr_addr = 15'h0300; wr_data = 24'h00FF00;
      for (int i = 0; i < 15; i++) begin
         #1;
         check($sformatf("starve wr_gnt[%0d]", i), 32'(wr_gnt), 32'((i % 5) == 4));
         check($sformatf("starve rd_gnt[%0d]", i), 32'(rd_gnt), 32'((i % 5) != 4));
         tick();
      end
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (4) tick();

      // Reset the cycle after a read grant: the in-flight read is cancelled.
      rd_req = 1'b1; rd_addr = 15'h0100;
      #1 check("midreset rd_gnt", 32'(rd_gnt), 32'd1);
      tick();
      rd_req = 1'b0; rst = 1'b1;
      check("midreset rd_valid c1", 32'(rd_valid), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         check($sformatf("midreset rd_valid[%0d]", i), 32'(rd_valid), 32'd0);
         tick();
      end

`ifdef FB_ARB_STATS_EN
      // Three unforced writes.
      for (int k = 0; k < 3; k++) begin
         wr_req = 1'b1; wr_addr = AW'(15'h0400 + k); wr_data = DW'(24'h010101 * (k + 1));
         tick();
      end
      wr_req = 1'b0;
      tick();
      // Two forced writes inside ten contended cycles.
      rd_req = 1'b1; rd_addr = 15'h028C;
      wr_req = 1'b1; wr_addr = 15'h0500; wr_data = 24'h0000FF;
      repeat (10) tick();
      // Unforced write granted in the frame_done cycle belongs to the next frame.
      rd_req = 1'b0; frame_done = 1'b1;
      #1 check("stats fd wr_gnt", 32'(wr_gnt), 32'd1);
      tick();
      frame_done = 1'b0; wr_req = 1'b0;
      check("stats frame1 wr", 32'(stat_wr_cnt), 32'd5);
      check("stats frame1 force", 32'(stat_force_cnt), 32'd2);
      repeat (3) tick();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      check("stats frame2 wr", 32'(stat_wr_cnt), 32'd1);
      check("stats frame2 force", 32'(stat_force_cnt), 32'd0);
`endif

      rd_req = 1'b0; wr_req = 1'b0;
      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
